// File: rtl/math_round_controller_pkg.sv
// Shared types and constants for the binary math game round controller.
package math_round_controller_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SUM_W  = 5;

  // Fibonacci feedback taps on q[7], q[5], q[4], q[3]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned DEFAULT_ROUNDS     = 8;
  localparam int unsigned DEFAULT_TIME_LIMIT = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ASK    = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Operand pair as sliced from the LFSR: high nibble is B, low nibble is A
  typedef struct packed {
    logic [NIB_W-1:0] b;
    logic [NIB_W-1:0] a;
  } operands_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/math_round_controller_operand_lfsr.sv
// Free-running 8-bit Fibonacci LFSR supplying the random operand pairs.
module operand_lfsr
  import math_round_controller_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge Clock) begin
    if (!Reset) q <= SEED;
    else        q <= {q[LFSR_W-2:0], lfsr_feedback(q)};
  end

endmodule

// File: rtl/math_round_controller.sv
// Game sequencer: issues operand pairs, times each round, checks answers and keeps score.
module math_round_controller
  import math_round_controller_pkg::*;
#(
  parameter int unsigned      ROUNDS       = DEFAULT_ROUNDS,
  parameter int unsigned      TIME_LIMIT   = DEFAULT_TIME_LIMIT,
  parameter int unsigned      RESULT_TICKS = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             StartPulse,
  input  logic             SubmitPulse,
  input  logic [SUM_W-1:0] Answer,
  input  logic             OneSecTick,
  output logic [NIB_W-1:0] OperandA,
  output logic [NIB_W-1:0] OperandB,
  output logic [NIB_W-1:0] TimeLeft,
  output logic [NIB_W-1:0] Score,
  output logic [NIB_W-1:0] Round,
  output logic             Active,
  output logic             Correct,
  output logic             Wrong,
  output logic             GameOver
);

  localparam logic [NIB_W-1:0] TIME_INIT  = NIB_W'(TIME_LIMIT);
  localparam logic [NIB_W-1:0] LAST_ROUND = NIB_W'(ROUNDS);
  localparam logic [NIB_W-1:0] LAST_TICK  = NIB_W'(RESULT_TICKS - 1);

  logic [LFSR_W-1:0] lfsr_q;

  state_t            state_q,     state_d;
  operands_t         ops_q,       ops_d;
  logic [NIB_W-1:0]  time_left_q, time_left_d;
  logic [NIB_W-1:0]  score_q,     score_d;
  logic [NIB_W-1:0]  round_q,     round_d;
  logic [NIB_W-1:0]  res_cnt_q,   res_cnt_d;
  logic [SUM_W-1:0]  answer_q,    answer_d;
  logic              active_q,    active_d;
  logic              correct_q,   correct_d;
  logic              wrong_q,     wrong_d;
  logic              game_over_q, game_over_d;
  logic [SUM_W-1:0]  sum_c;

  operand_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .q     (lfsr_q)
  );

  // Zero-extended so 15+15 compares as 30 rather than wrapping
  assign sum_c = SUM_W'(ops_q.a) + SUM_W'(ops_q.b);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    round_d     = round_q;
    res_cnt_d   = res_cnt_q;
    answer_d    = answer_q;
    active_d    = active_q;
    correct_d   = correct_q;
    wrong_d     = wrong_q;
    game_over_d = game_over_q;

    unique case (state_q)
      IDLE: begin
        if (StartPulse) state_d = LOAD;
      end

      LOAD: begin
        ops_d       = operands_t'(lfsr_q);
        time_left_d = TIME_INIT;
        round_d     = round_q + NIB_W'(1);
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        active_d    = 1'b1;
        state_d     = ASK;
      end

      // A submit in the same cycle as the final tick takes priority over the timeout
      ASK: begin
        if (SubmitPulse) begin
          answer_d = Answer;
          active_d = 1'b0;
          state_d  = CHECK;
        end else if (OneSecTick) begin
          if (time_left_q == NIB_W'(1)) begin
            time_left_d = '0;
            wrong_d     = 1'b1;
            active_d    = 1'b0;
            state_d     = RESULT;
          end else begin
            time_left_d = time_left_q - NIB_W'(1);
          end
        end
      end

      CHECK: begin
        if (answer_q == sum_c) begin
          score_d   = score_q + NIB_W'(1);
          correct_d = 1'b1;
        end else begin
          wrong_d = 1'b1;
        end
        state_d = RESULT;
      end

      RESULT: begin
        if (OneSecTick) begin
          if (res_cnt_q == LAST_TICK) begin
            res_cnt_d = '0;
            correct_d = 1'b0;
            wrong_d   = 1'b0;
            if (round_q == LAST_ROUND) begin
              game_over_d = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = LOAD;
            end
          end else begin
            res_cnt_d = res_cnt_q + NIB_W'(1);
          end
        end
      end

      DONE: begin
        if (StartPulse) begin
          score_d     = '0;
          round_d     = '0;
          game_over_d = 1'b0;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d     = IDLE;
        ops_d       = '0;
        time_left_d = TIME_INIT;
        score_d     = '0;
        round_d     = '0;
        res_cnt_d   = '0;
        answer_d    = '0;
        active_d    = 1'b0;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        game_over_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ops_q       <= '0;
      time_left_q <= TIME_INIT;
      score_q     <= '0;
      round_q     <= '0;
      res_cnt_q   <= '0;
      answer_q    <= '0;
      active_q    <= 1'b0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      round_q     <= round_d;
      res_cnt_q   <= res_cnt_d;
      answer_q    <= answer_d;
      active_q    <= active_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      game_over_q <= game_over_d;
    end
  end

  assign OperandA = ops_q.a;
  assign OperandB = ops_q.b;
  assign TimeLeft = time_left_q;
  assign Score    = score_q;
  assign Round    = round_q;
  assign Active   = active_q;
  assign Correct  = correct_q;
  assign Wrong    = wrong_q;
  assign GameOver = game_over_q;

endmodule

// File: tb/tb_math_round_controller.sv
// Scoreboard bench for math_round_controller: plays a full game plus timeout, tie and reset cases.
module tb_math_round_controller;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       StartPulse = 1'b0;
  logic       SubmitPulse = 1'b0;
  logic       OneSecTick = 1'b0;
  logic [4:0] Answer = 5'd0;
  logic [3:0] OperandA, OperandB, TimeLeft, Score, Round;
  logic       Active, Correct, Wrong, GameOver;

  always #5 Clock = ~Clock;

  math_round_controller dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .StartPulse  (StartPulse),
    .SubmitPulse (SubmitPulse),
    .Answer      (Answer),
    .OneSecTick  (OneSecTick),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .TimeLeft    (TimeLeft),
    .Score       (Score),
    .Round       (Round),
    .Active      (Active),
    .Correct     (Correct),
    .Wrong       (Wrong),
    .GameOver    (GameOver)
  );

  typedef struct packed {
    logic       correct;
    logic       wrong;
    logic [3:0] score;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_score = 0;
  int         exp_round = 0;
  logic [3:0] exp_a = 4'd0;
  logic [3:0] exp_b = 4'd0;
  logic [7:0] m;

  wire [23:0] outs = {OperandA, OperandB, TimeLeft, Score, Round, Active, Correct, Wrong, GameOver};
  localparam logic [23:0] IDLE_OUTS = 24'h00A000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Reference LFSR, stepped on the same edges as the design
  always @(posedge Clock) begin
    if (!Reset) m <= 8'hA5;
    else        m <= lfsr_next(m);
  end

  task automatic pulse_start();
    StartPulse = 1'b1; @(negedge Clock); StartPulse = 1'b0;
  endtask

  task automatic pulse_submit();
    SubmitPulse = 1'b1; @(negedge Clock); SubmitPulse = 1'b0;
  endtask

  task automatic pulse_tick();
    OneSecTick = 1'b1; @(negedge Clock); OneSecTick = 1'b0;
  endtask

  // Begin a round (Start or the final RESULT tick), optionally timed to land a chosen LFSR value
  task automatic launch(input bit by_start, input bit targeted, input logic [7:0] target);
    int w = 0;
    logic [7:0] nxt;
    while (targeted && lfsr_next(m) !== target && w < 600) begin
      @(negedge Clock); w++;
    end
    if (targeted) begin
      checks++;
      if (w >= 600) begin errors++; $display("FAIL launch_align: waited %0d cycles for lfsr %h", w, target); end
    end
    nxt = lfsr_next(m);
    exp_a = nxt[3:0];
    exp_b = nxt[7:4];
    if (by_start) pulse_start(); else pulse_tick();
    exp_round++;
    checks++;
    if (Active !== 1'b0) begin errors++; $display("FAIL load_active: got %b want 0", Active); end
    @(negedge Clock);
    checks++;
    if ({OperandA, OperandB} !== {exp_a, exp_b}) begin
      errors++; $display("FAIL operands: got %0d,%0d want %0d,%0d", OperandA, OperandB, exp_a, exp_b);
    end
    checks++;
    if ({Round, Score, TimeLeft, Active, Correct, Wrong, GameOver} !== {4'(exp_round), 4'(exp_score), 4'd10, 4'b1000}) begin
      errors++;
      $display("FAIL ask_entry: got round=%0d score=%0d tl=%0d a/c/w/g=%b%b%b%b want round=%0d score=%0d tl=10 a/c/w/g=1000",
               Round, Score, TimeLeft, Active, Correct, Wrong, GameOver, exp_round, exp_score);
    end
  endtask

  // Submit an answer (optionally with a coincident tick), score it through the queue
  task automatic submit(input logic [4:0] ans, input bit with_tick);
    exp_t e;
    int   cyc;
    e.correct = (ans == ({1'b0, exp_a} + {1'b0, exp_b}));
    e.wrong   = !e.correct;
    if (e.correct) exp_score++;
    e.score = 4'(exp_score);
    sb.push_back(e);
    Answer = ans; SubmitPulse = 1'b1; OneSecTick = with_tick;
    @(negedge Clock);
    SubmitPulse = 1'b0; OneSecTick = 1'b0;
    cyc = 1;
    checks++;
    if (Active !== 1'b0) begin errors++; $display("FAIL submit_active: got %b want 0", Active); end
    while (!(Correct | Wrong) && cyc < 10) begin @(negedge Clock); cyc++; end
    e = sb.pop_front();
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL lamp_latency: got %0d cycles want 2", cyc); end
    checks++;
    if ({Correct, Wrong, Score} !== {e.correct, e.wrong, e.score}) begin
      errors++; $display("FAIL lamp_score: got c=%b w=%b score=%0d want c=%b w=%b score=%0d",
                         Correct, Wrong, Score, e.correct, e.wrong, e.score);
    end
  endtask

  task automatic hold_tick();
    pulse_tick();
    checks++;
    if ((Correct | Wrong) !== 1'b1) begin errors++; $display("FAIL lamp_hold: got c=%b w=%b want one lit", Correct, Wrong); end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    checks++;
    if (outs !== IDLE_OUTS) begin errors++; $display("FAIL reset_values: got %h want %h", outs, IDLE_OUTS); end
    pulse_submit();
    pulse_tick();
    @(negedge Clock);
    checks++;
    if (outs !== IDLE_OUTS) begin errors++; $display("FAIL idle_ignores: got %h want %h", outs, IDLE_OUTS); end
  endtask

  task automatic test_correct_answer();
    launch(1'b1, 1'b0, 8'h00);
    submit({1'b0, exp_a} + {1'b0, exp_b}, 1'b0);
    hold_tick();
    launch(1'b0, 1'b1, 8'hFF);
  endtask

  task automatic test_wide_sum();
    checks++;
    if ({OperandA, OperandB} !== 8'hFF) begin errors++; $display("FAIL max_operands: got %0d,%0d want 15,15", OperandA, OperandB); end
    submit(5'd30, 1'b0);
    hold_tick();
    launch(1'b0, 1'b1, 8'hFF);
    submit(5'd14, 1'b0);
    hold_tick();
    launch(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_timeout();
    exp_t e;
    e.correct = 1'b0; e.wrong = 1'b1; e.score = 4'(exp_score);
    sb.push_back(e);
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (TimeLeft !== 4'(11 - i)) begin errors++; $display("FAIL countdown: got %0d want %0d", TimeLeft, 11 - i); end
      pulse_tick();
      if (i < 10) begin
        checks++;
        if ({Active, Wrong} !== 2'b10) begin errors++; $display("FAIL early_timeout: got a=%b w=%b at tick %0d", Active, Wrong, i); end
      end
    end
    e = sb.pop_front();
    checks++;
    if ({TimeLeft, Active, Correct, Wrong, Score} !== {4'd0, 1'b0, e.correct, e.wrong, e.score}) begin
      errors++; $display("FAIL timeout: got tl=%0d a=%b c=%b w=%b score=%0d want tl=0 a=0 c=0 w=1 score=%0d",
                         TimeLeft, Active, Correct, Wrong, Score, e.score);
    end
    hold_tick();
    launch(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_submit_beats_tick();
    repeat (9) pulse_tick();
    checks++;
    if (TimeLeft !== 4'd1) begin errors++; $display("FAIL tie_setup: got tl=%0d want 1", TimeLeft); end
    submit({1'b0, exp_a} + {1'b0, exp_b}, 1'b1);
    checks++;
    if (TimeLeft !== 4'd1) begin errors++; $display("FAIL tie_timeleft: got %0d want 1", TimeLeft); end
    hold_tick();
    launch(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_game();
    submit({1'b0, exp_a} + {1'b0, exp_b}, 1'b0);
    hold_tick();
    launch(1'b0, 1'b0, 8'h00);
    submit({1'b0, exp_a} + {1'b0, exp_b}, 1'b0);
    hold_tick();
    launch(1'b0, 1'b0, 8'h00);
    submit(({1'b0, exp_a} + {1'b0, exp_b}) ^ 5'd1, 1'b0);
    hold_tick();
    pulse_tick();
    checks++;
    if ({GameOver, Score, Round, Active, Correct, Wrong, OperandA, OperandB} !== {1'b1, 4'd5, 4'd8, 3'b000, exp_a, exp_b}) begin
      errors++; $display("FAIL game_over: got g=%b score=%0d round=%0d a/c/w=%b%b%b ops=%0d,%0d want g=1 score=5 round=8 a/c/w=000 ops=%0d,%0d",
                         GameOver, Score, Round, Active, Correct, Wrong, OperandA, OperandB, exp_a, exp_b);
    end
    pulse_submit();
    pulse_tick();
    checks++;
    if ({GameOver, Score, Round} !== {1'b1, 4'd5, 4'd8}) begin
      errors++; $display("FAIL done_hold: got g=%b score=%0d round=%0d want g=1 score=5 round=8", GameOver, Score, Round);
    end
    exp_score = 0;
    exp_round = 0;
    launch(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_no_restart_and_reset();
    pulse_start();
    @(negedge Clock);
    checks++;
    if ({Round, Active} !== {4'd1, 1'b1}) begin errors++; $display("FAIL mid_start: got round=%0d a=%b want round=1 a=1", Round, Active); end
    pulse_tick();
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (outs !== IDLE_OUTS) begin errors++; $display("FAIL mid_reset: got %h want %h", outs, IDLE_OUTS); end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (outs !== IDLE_OUTS) begin errors++; $display("FAIL post_reset: got %h want %h", outs, IDLE_OUTS); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clock);
    test_reset();
    test_correct_answer();
    test_wide_sum();
    test_timeout();
    test_submit_beats_tick();
    test_full_game();
    test_no_restart_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
